// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-controller state encoding, FIFO entry
// layout and the baud/parity codes understood by both UART_Rx and UART_Tx.
package uart_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CFG_WAIT = 2'd1,
    SETTLE   = 2'd2
  } rx_ctrl_state_t;

  typedef struct packed {
    logic [2:0] err;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_57600  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  // Any nonzero error bit from UART_Rx marks the frame as bad.
  function automatic logic is_frame_err(input logic [2:0] err);
    return err != 3'b000;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. The head entry is presented from storage addressed by
// a registered read pointer, so a pushed word is visible one cycle later.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Empty FIFO shows zero so the head never exposes stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; validity is carried by level/pointers,
  // and leaving it unreset lets it map onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-2 depth.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller between UART_Rx and the system bus. Owns the Rx
// configuration (applied only while the receiver is idle, followed by a settle
// window), queues completed frames into a FIFO and keeps error statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SETTLE_CYC = 16,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr,
  input  logic [1:0]                    cfg_baud,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_drop_err,
  input  logic                          clr_stats,
  input  logic                          rx_active,
  input  logic                          rx_done,
  input  logic [2:0]                    rx_error,
  input  logic [7:0]                    rx_data,
  output logic [1:0]                    baud_rate,
  output logic [1:0]                    parity_type,
  output logic                          cfg_busy,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  output logic [2:0]                    m_err,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [ERR_CNT_W-1:0]          err_cnt
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  rx_ctrl_state_t state, state_next;

  logic          active_s1, active_s2;
  logic          done_s1, done_s2, done_d;
  logic          done_pulse;

  logic [1:0]    pend_baud, pend_parity;
  logic          pend_drop;
  logic          drop_err;
  logic [SW-1:0] settle_cnt;
  logic          apply;

  logic          cap_en, cap_err, cap_keep;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  rx_entry_t     push_entry, head_entry;

  assign done_pulse = done_s2 && !done_d;

  // Two-flop synchronisers for the UART_Rx status flags plus done edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_s1 <= 1'b0;
      active_s2 <= 1'b0;
      done_s1   <= 1'b0;
      done_s2   <= 1'b0;
      done_d    <= 1'b0;
    end else begin
      active_s1 <= rx_active;
      active_s2 <= active_s1;
      done_s1   <= rx_done;
      done_s2   <= done_s1;
      done_d    <= done_s2;
    end
  end

  // Next-state logic; a fresh cfg_wr always restarts the wait for idle.
  // NOTE: state_next is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (cfg_wr) state_next = CFG_WAIT;
      CFG_WAIT: if (!cfg_wr && !active_s2 && !done_pulse) state_next = SETTLE;
      SETTLE: begin
        if (cfg_wr)                   state_next = CFG_WAIT;
        else if (settle_cnt == SW'(1)) state_next = RUN;
      end
      default:  state_next = RUN;
    endcase
  end

  assign apply = (state == CFG_WAIT) && (state_next == SETTLE);

  // State register; cfg_busy is registered from the next state so it tracks state!=RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cfg_busy <= 1'b0;
    end else begin
      state    <= state_next;
      cfg_busy <= (state_next != RUN);
    end
  end

  // Pending/active configuration and the settle-window counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_baud   <= BAUD_9600;
      pend_parity <= PARITY_NONE;
      pend_drop   <= 1'b0;
      baud_rate   <= BAUD_9600;
      parity_type <= PARITY_NONE;
      drop_err    <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      if (cfg_wr) begin
        pend_baud   <= cfg_baud;
        pend_parity <= cfg_parity;
        pend_drop   <= cfg_drop_err;
      end
      if (apply) begin
        baud_rate   <= pend_baud;
        parity_type <= pend_parity;
        drop_err    <= pend_drop;
        settle_cnt  <= SW'(SETTLE_CYC);
      end else if (state == SETTLE && !cfg_wr && settle_cnt != '0) begin
        settle_cnt  <= settle_cnt - 1'b1;
      end
    end
  end

  // Frame capture decisions; frames finishing during the settle window are ignored.
  assign cap_en     = done_pulse && (state != SETTLE);
  assign cap_err    = is_frame_err(rx_error);
  assign cap_keep   = cap_en && !(cap_err && drop_err);
  assign fifo_pop   = m_valid && m_ready;
  assign fifo_push  = cap_keep && (!fifo_full || fifo_pop);
  assign push_entry = '{err: rx_error, data: rx_data};

  // Error statistics: saturating error counter and sticky overflow, clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clr_stats) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (cap_en && cap_err && err_cnt != {ERR_CNT_W{1'b1}})
        err_cnt <= err_cnt + 1'b1;
      if (cap_keep && fifo_full && !fifo_pop)
        overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = head_entry.data;
  assign m_err   = head_entry.err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: inputs are driven and outputs sampled on
// the falling clock edge, expected values are hand-computed constants.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_baud = 2'b00;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_drop_err = 1'b0;
  logic       clr_stats = 1'b0;
  logic       rx_active = 1'b0;
  logic       rx_done = 1'b0;
  logic [2:0] rx_error = 3'b000;
  logic [7:0] rx_data = 8'h00;
  logic [1:0] baud_rate;
  logic [1:0] parity_type;
  logic       cfg_busy;
  logic       m_valid;
  logic [7:0] m_data;
  logic [2:0] m_err;
  logic       m_ready = 1'b0;
  logic [3:0] fifo_level;
  logic       overflow;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr       (cfg_wr),
    .cfg_baud     (cfg_baud),
    .cfg_parity   (cfg_parity),
    .cfg_drop_err (cfg_drop_err),
    .clr_stats    (clr_stats),
    .rx_active    (rx_active),
    .rx_done      (rx_done),
    .rx_error     (rx_error),
    .rx_data      (rx_data),
    .baud_rate    (baud_rate),
    .parity_type  (parity_type),
    .cfg_busy     (cfg_busy),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_err        (m_err),
    .m_ready      (m_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [2:0] e, input int hold);
    rx_data  = d;
    rx_error = e;
    rx_done  = 1'b1;
    tick(hold);
    rx_done  = 1'b0;
    tick(3);
  endtask

  task automatic write_cfg(input logic [1:0] b, input logic [1:0] p, input logic d);
    cfg_baud     = b;
    cfg_parity   = p;
    cfg_drop_err = d;
    cfg_wr       = 1'b1;
    tick(1);
    cfg_wr       = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cfg_busy && n < 100) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, cfg_busy}, 32'd0);
  endtask

  initial begin
    // 1: reset state, then three clean frames drained in order
    tick(3);
    check("rst_baud", baud_rate, 2'b00);
    check("rst_parity", parity_type, 2'b00);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 8'h00);
    check("rst_err", m_err, 3'b000);
    check("rst_level", fifo_level, 4'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_errcnt", err_cnt, 8'd0);
    rst = 1'b0;
    tick(2);
    send_frame(8'h55, 3'b000, 4);
    send_frame(8'hA3, 3'b000, 4);
    send_frame(8'h00, 3'b000, 4);
    check("t1_level3", fifo_level, 4'd3);
    m_ready = 1'b1;
    check("t1_d0", m_data, 8'h55);
    check("t1_e0", m_err, 3'b000);
    tick(1);
    check("t1_d1", m_data, 8'hA3);
    tick(1);
    check("t1_d2", m_data, 8'h00);
    check("t1_v2", m_valid, 1'b1);
    tick(1);
    check("t1_level0", fifo_level, 4'd0);
    check("t1_valid0", m_valid, 1'b0);
    check("t1_errcnt", err_cnt, 8'd0);
    m_ready = 1'b0;

    // 2: overfill with consumer stalled, then drain
    for (int i = 0; i < DEPTH + 2; i++) send_frame(8'h10 + 8'(i), 3'b000, 4);
    check("t2_level_full", fifo_level, 4'd8);
    check("t2_ovf", overflow, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain", m_data, 8'h10 + 8'(i));
      m_ready = 1'b1;
      tick(1);
      m_ready = 1'b0;
    end
    check("t2_level0", fifo_level, 4'd0);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    check("t2_ovf_clr", overflow, 1'b0);

    // 3: error frame queued, then dropped once drop_err is applied
    send_frame(8'h3C, 3'b010, 4);
    check("t3_level", fifo_level, 4'd1);
    check("t3_merr", m_err, 3'b010);
    check("t3_mdata", m_data, 8'h3C);
    check("t3_errcnt1", err_cnt, 8'd1);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    write_cfg(2'b00, 2'b00, 1'b1);
    wait_idle("t3_idle");
    send_frame(8'h77, 3'b001, 4);
    check("t3_dropped", fifo_level, 4'd0);
    check("t3_errcnt2", err_cnt, 8'd2);

    // 4: config deferred while active, then settle window swallows a done edge
    rx_active = 1'b1;
    tick(3);
    write_cfg(2'b10, 2'b01, 1'b0);
    tick(4);
    check("t4_baud_hold", baud_rate, 2'b00);
    check("t4_par_hold", parity_type, 2'b00);
    check("t4_busy_wait", cfg_busy, 1'b1);
    send_frame(8'h81, 3'b000, 4);
    check("t4_cap_wait", fifo_level, 4'd1);
    check("t4_cap_data", m_data, 8'h81);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    rx_active = 1'b0;
    tick(3);
    check("t4_baud_new", baud_rate, 2'b10);
    check("t4_par_new", parity_type, 2'b01);
    check("t4_busy_settle", cfg_busy, 1'b1);
    send_frame(8'h42, 3'b000, 4);
    tick(8);
    check("t4_busy_last", cfg_busy, 1'b1);
    tick(1);
    check("t4_busy_done", cfg_busy, 1'b0);
    check("t4_ignored", fifo_level, 4'd0);
    check("t4_errcnt", err_cnt, 8'd2);

    // 5: long done pulse gives one entry; push+pop on full FIFO
    send_frame(8'h99, 3'b000, 10);
    check("t5_one", fifo_level, 4'd1);
    check("t5_data", m_data, 8'h99);
    for (int i = 0; i < DEPTH - 1; i++) send_frame(8'hB0 + 8'(i), 3'b000, 4);
    check("t5_full", fifo_level, 4'd8);
    rx_data  = 8'hC0;
    rx_error = 3'b000;
    rx_done  = 1'b1;
    tick(2);
    m_ready  = 1'b1;
    tick(1);
    m_ready  = 1'b0;
    tick(1);
    rx_done  = 1'b0;
    tick(3);
    check("t5_pp_level", fifo_level, 4'd8);
    check("t5_pp_ovf", overflow, 1'b0);
    check("t5_pp_head", m_data, 8'hB0);

    // 6: error counter saturation, clear-wins, reset mid-drain
    write_cfg(2'b10, 2'b01, 1'b1);
    wait_idle("t6_idle");
    for (int i = 0; i < 253; i++) send_frame(8'h11, 3'b001, 2);
    check("t6_sat", err_cnt, 8'd255);
    send_frame(8'h12, 3'b001, 2);
    check("t6_sat_hold", err_cnt, 8'd255);
    check("t6_level_kept", fifo_level, 4'd8);
    rx_data  = 8'hEE;
    rx_error = 3'b100;
    rx_done  = 1'b1;
    tick(2);
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    tick(1);
    rx_done  = 1'b0;
    tick(3);
    check("t6_clr_wins", err_cnt, 8'd0);
    m_ready = 1'b1;
    tick(3);
    check("t6_draining", fifo_level, 4'd5);
    rst = 1'b1;
    #1;
    check("t6_rst_level", fifo_level, 4'd0);
    check("t6_rst_valid", m_valid, 1'b0);
    check("t6_rst_data", m_data, 8'h00);
    check("t6_rst_baud", baud_rate, 2'b00);
    check("t6_rst_par", parity_type, 2'b00);
    check("t6_rst_busy", cfg_busy, 1'b0);
    check("t6_rst_errcnt", err_cnt, 8'd0);
    m_ready = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
